// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register for the RV32IM 5-stage core, with immediate-format
// pre-decode registered alongside the instruction so decode sees stable operands.
module if_id_pipeline_reg #(
   parameter int                XLEN      = 32,
   parameter logic [31:0]       NOP_INSTR = 32'h00000013,
   parameter logic [XLEN-1:0]   RESET_PC  = {XLEN{1'b0}}
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [31:0]       IF_INSTR,
   input  logic [XLEN-1:0]   IF_PC,
   input  logic              IF_VALID,
   input  logic              STALL,
   input  logic              FLUSH,
   output logic [31:0]       ID_INSTR,
   output logic [XLEN-1:0]   ID_PC,
   output logic [XLEN-1:0]   ID_PC4,
   output logic              ID_VALID,
   output logic [24:0]       ID_INSTR_BITS,
   output logic [2:0]        ID_IMM_SEL,
   output logic              ID_ILLEGAL
);

   localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

   // Returns {illegal, imm_sel}; OP (incl. M-ext), SYSTEM and FENCE are legal.
   function automatic logic [3:0] predecode(input logic [6:0] opc);
      case (opc)
         7'b0010011, 7'b0000011, 7'b1100111: predecode = {1'b0, 3'b000};
         7'b0100011:                         predecode = {1'b0, 3'b001};
         7'b1100011:                         predecode = {1'b0, 3'b010};
         7'b0110111, 7'b0010111:             predecode = {1'b0, 3'b011};
         7'b1101111:                         predecode = {1'b0, 3'b100};
         7'b0110011:                         predecode = {1'b0, 3'b111};
         7'b1110011, 7'b0001111:             predecode = {1'b0, 3'b000};
         default:                            predecode = {1'b1, 3'b111};
      endcase
   endfunction

   logic [31:0]     instr_d,   instr_q;
   logic [XLEN-1:0] pc_d,      pc_q;
   logic [XLEN-1:0] pc4_d,     pc4_q;
   logic            valid_d,   valid_q;
   logic [2:0]      imm_sel_d, imm_sel_q;
   logic            illegal_d, illegal_q;
   logic [31:0]     load_instr_s;
   logic [3:0]      dec_s;

   // Next-state selection: flush beats stall beats load; bubbles load a NOP.
   always_comb begin
      instr_d      = instr_q;
      pc_d         = pc_q;
      pc4_d        = pc4_q;
      valid_d      = valid_q;
      imm_sel_d    = imm_sel_q;
      illegal_d    = illegal_q;
      load_instr_s = IF_VALID ? IF_INSTR : NOP_INSTR;
      dec_s        = predecode(load_instr_s[6:0]);
      if (FLUSH) begin
         instr_d   = NOP_INSTR;
         valid_d   = 1'b0;
         imm_sel_d = 3'b000;
         illegal_d = 1'b0;
      end else if (STALL) begin
         instr_d   = instr_q;
         valid_d   = valid_q;
         imm_sel_d = imm_sel_q;
         illegal_d = illegal_q;
      end else begin
         instr_d   = load_instr_s;
         pc_d      = IF_PC;
         pc4_d     = IF_PC + PC_STEP;
         valid_d   = IF_VALID;
         imm_sel_d = dec_s[2:0];
         illegal_d = IF_VALID & dec_s[3];
      end
   end

   // Pipeline state with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         instr_q   <= NOP_INSTR;
         pc_q      <= RESET_PC;
         pc4_q     <= RESET_PC + PC_STEP;
         valid_q   <= 1'b0;
         imm_sel_q <= 3'b000;
         illegal_q <= 1'b0;
      end else begin
         instr_q   <= instr_d;
         pc_q      <= pc_d;
         pc4_q     <= pc4_d;
         valid_q   <= valid_d;
         imm_sel_q <= imm_sel_d;
         illegal_q <= illegal_d;
      end
   end

   assign ID_INSTR      = instr_q;
   assign ID_PC         = pc_q;
   assign ID_PC4        = pc4_q;
   assign ID_VALID      = valid_q;
   assign ID_INSTR_BITS = instr_q[31:7];
   assign ID_IMM_SEL    = imm_sel_q;
   assign ID_ILLEGAL    = illegal_q;

endmodule
